// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// No logic; compile before any file that imports it.
// Consumers: regfile_sb, regfile_scoreboard, and the bench.
package regfile_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int NREG_DEF      = 8;
    localparam int WATCH_IDX_DEF = 2;
    localparam int AW_DEF        = $clog2(NREG_DEF);

    // Register address for the default-sized file
    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: per-register write-in-flight flags, pending count, RAW/WAW stall.
// Latency: stall/busy_a/busy_b combinational; busy set visible one cycle after accept.
// Backpressure: stall asserted while a hazard exists; write-back never stalls. Optional: REGFILE_ZERO_REG_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] ra,
    input  logic [AW-1:0] rb,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_addr,
    output logic          busy_a,
    output logic          busy_b,
    output logic          stall,
    output logic [AW:0]   pending
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            hit_a;
    logic            hit_b;
    logic            hit_i;
    logic            accept;
    logic            set_ok;
    logic            inc;
    logic            dec;

    // Hazard detection, issue acceptance and next busy vector (set wins over clear)
    always_comb begin
        hit_a  = wr_en && (wr_addr == ra);
        hit_b  = wr_en && (wr_addr == rb);
        hit_i  = wr_en && (wr_addr == iss_addr);
        busy_a = busy[ra] && !hit_a;
        busy_b = busy[rb] && !hit_b;
        stall  = iss_en && (busy_a || busy_b || (busy[iss_addr] && !hit_i));
        accept = iss_en && !stall;
`ifdef REGFILE_ZERO_REG_EN
        // r0 is constant, so it never carries a write in flight
        set_ok = accept && (iss_addr != '0);
`else
        set_ok = accept;
`endif
        inc      = set_ok && !busy[iss_addr];
        dec      = wr_en && busy[wr_addr] && !(set_ok && (iss_addr == wr_addr));
        busy_nxt = busy;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    // Busy flags and pending count; simultaneous inc and dec cancel
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy    <= '0;
            pending <= '0;
        end else begin
            busy <= busy_nxt;
            if (inc && !dec) begin
                pending <= pending + ONE;
            end else if (dec && !inc) begin
                pending <= pending - ONE;
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file, 2 combinational bypassed read ports, 1 write-back port, busy scoreboard.
// Latency: reads 0 cycles (write-through bypass); array write visible next cycle.
// Backpressure: issue held off by stall on RAW/WAW; write-back always accepted. Optional: REGFILE_ZERO_REG_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NREG      = NREG_DEF,
    parameter int AW        = $clog2(NREG),
    parameter int WATCH_IDX = WATCH_IDX_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AW-1:0]     ra,
    input  logic [AW-1:0]     rb,
    output logic [DATA_W-1:0] ar,
    output logic [DATA_W-1:0] br,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              stall,
    output logic [AW:0]       pending,
    output logic [DATA_W-1:0] reg_watch
);

    logic [DATA_W-1:0] r [NREG];
    logic              wr_ok;

    // Effective write enable; r0 writes are dropped when it is hardwired
    always_comb begin
        wr_ok = wr_en;
`ifdef REGFILE_ZERO_REG_EN
        if (wr_addr == '0) begin
            wr_ok = 1'b0;
        end
`endif
    end

    // Data array
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r[i] <= '0;
            end
        end else if (wr_ok) begin
            r[wr_addr] <= wr_data;
        end
    end

    // Read ports with same-cycle write-through bypass
    always_comb begin
        ar        = (wr_ok && (wr_addr == ra)) ? wr_data : r[ra];
        br        = (wr_ok && (wr_addr == rb)) ? wr_data : r[rb];
        reg_watch = r[WATCH_IDX];
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .ra       (ra),
        .rb       (rb),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .stall    (stall),
        .pending  (pending)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, RAW/WAW stall, set-over-clear, fill/drain.
// Inputs driven at falling edge, outputs sampled 1 time unit later.
// Build with REGFILE_ZERO_REG_EN defined to exercise the hardwired r0.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = DATA_W_DEF;
    localparam int NR = NREG_DEF;
    localparam int AW = AW_DEF;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    reg_addr_t       ra = '0, rb = '0, wr_addr = '0, iss_addr = '0;
    logic            wr_en = 1'b0, iss_en = 1'b0;
    logic [DW-1:0]   wr_data = '0;
    logic [DW-1:0]   ar, br, reg_watch;
    logic            busy_a, busy_b, stall;
    logic [AW:0]     pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    regfile_sb dut (
        .clock(clock), .reset(reset), .ra(ra), .rb(rb), .ar(ar), .br(br),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .busy_a(busy_a), .busy_b(busy_b), .stall(stall),
        .pending(pending), .reg_watch(reg_watch)
    );

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; wr_addr = '0; iss_addr = '0; wr_data = '0;
    endtask

    task automatic test_reset();
        // Initial reset held from time 0
        #2;
        n_tests++; if (pending !== '0) begin n_fail++; $display("FAIL reset_init_pending: got %0d want 0", pending); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_init_stall: got %b want 0", stall); end
        @(negedge clock); reset = 1'b1;
        // Load r2 and mark r5 busy
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234; iss_en = 1'b1; iss_addr = 3'd5;
        @(negedge clock);
        idle(); ra = 3'd2; rb = 3'd5;
        #1;
        n_tests++; if (reg_watch !== 16'h1234) begin n_fail++; $display("FAIL pre_reset_watch: got %h want 1234", reg_watch); end
        n_tests++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy_b: got %b want 1", busy_b); end
        n_tests++; if (pending !== 4'd1) begin n_fail++; $display("FAIL pre_reset_pending: got %0d want 1", pending); end
        // Mid-run reset, effect must be immediate
        reset = 1'b0;
        #1;
        n_tests++; if (ar !== 16'h0) begin n_fail++; $display("FAIL reset_ar: got %h want 0", ar); end
        n_tests++; if (br !== 16'h0) begin n_fail++; $display("FAIL reset_br: got %h want 0", br); end
        n_tests++; if (reg_watch !== 16'h0) begin n_fail++; $display("FAIL reset_watch: got %h want 0", reg_watch); end
        n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending); end
        n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", busy_b); end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF; ra = 3'd3; rb = 3'd0;
        #1;
        n_tests++; if (ar !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_ar: got %h want beef", ar); end
        n_tests++; if (br !== 16'h0000) begin n_fail++; $display("FAIL bypass_br_other: got %h want 0", br); end
        @(negedge clock);
        idle(); ra = 3'd3; rb = 3'd3;
        #1;
        n_tests++; if (ar !== 16'hBEEF) begin n_fail++; $display("FAIL array_ar: got %h want beef", ar); end
        n_tests++; if (br !== 16'hBEEF) begin n_fail++; $display("FAIL array_br: got %h want beef", br); end
    endtask

    task automatic test_raw();
        @(negedge clock);
        ra = 3'd0; rb = 3'd0; iss_en = 1'b1; iss_addr = 3'd4;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue_stall: got %b want 0", stall); end
        @(negedge clock);
        idle(); iss_en = 1'b1; iss_addr = 3'd1; ra = 3'd4; rb = 3'd0;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", stall); end
        n_tests++; if (pending !== 4'd1) begin n_fail++; $display("FAIL raw_pending: got %0d want 1", pending); end
        n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL raw_busy_a: got %b want 1", busy_a); end
        // Write-back in the same cycle resolves the hazard
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h00AA;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_resolved_stall: got %b want 0", stall); end
        n_tests++; if (ar !== 16'h00AA) begin n_fail++; $display("FAIL raw_resolved_ar: got %h want 00aa", ar); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL raw_resolved_busy_a: got %b want 0", busy_a); end
        // r4 cleared, r1 set: pending unchanged
        @(negedge clock);
        idle(); ra = 3'd1; rb = 3'd4;
        #1;
        n_tests++; if (pending !== 4'd1) begin n_fail++; $display("FAIL raw_swap_pending: got %0d want 1", pending); end
        n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL raw_r1_busy: got %b want 1", busy_a); end
        n_tests++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL raw_r4_free: got %b want 0", busy_b); end
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0011;
        @(negedge clock);
        idle();
        #1;
        n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL raw_drain_pending: got %0d want 0", pending); end
    endtask

    task automatic test_waw();
        @(negedge clock);
        ra = 3'd0; rb = 3'd0; iss_en = 1'b1; iss_addr = 3'd6;
        @(negedge clock);
        idle(); iss_en = 1'b1; iss_addr = 3'd6;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b want 1", stall); end
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5555;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_resolved_stall: got %b want 0", stall); end
        @(negedge clock);
        idle(); ra = 3'd6;
        #1;
        n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL waw_set_wins: got %b want 1", busy_a); end
        n_tests++; if (pending !== 4'd1) begin n_fail++; $display("FAIL waw_pending: got %0d want 1", pending); end
        n_tests++; if (ar !== 16'h5555) begin n_fail++; $display("FAIL waw_data: got %h want 5555", ar); end
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
        @(negedge clock);
        idle();
        #1;
        n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL waw_drain_pending: got %0d want 0", pending); end
    endtask

    task automatic test_back_to_back();
        logic [AW:0] want;
`ifdef REGFILE_ZERO_REG_EN
        want = 4'd7;
`else
        want = 4'd8;
`endif
        for (int i = 0; i < NR; i++) begin
            @(negedge clock);
            idle(); iss_en = 1'b1; iss_addr = 3'(i); ra = 3'(i); rb = 3'(i);
            #1;
            n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fill_stall_%0d: got %b want 0", i, stall); end
        end
        @(negedge clock);
        idle();
        #1;
        n_tests++; if (pending !== want) begin n_fail++; $display("FAIL fill_pending: got %0d want %0d", pending, want); end
        for (int i = 0; i < NR; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'(16'hA000 + i);
            @(negedge clock);
        end
        idle();
        #1;
        n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL drain_pending: got %0d want 0", pending); end
        // Extra write to a free register must not underflow
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
        @(negedge clock);
        idle(); ra = 3'd5;
        #1;
        n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL underflow_pending: got %0d want 0", pending); end
        n_tests++; if (ar !== 16'hA005) begin n_fail++; $display("FAIL drain_data_r5: got %h want a005", ar); end
    endtask

`ifdef REGFILE_ZERO_REG_EN
    task automatic test_zero_reg();
        @(negedge clock);
        idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; ra = 3'd0; rb = 3'd0;
        #1;
        n_tests++; if (ar !== 16'h0) begin n_fail++; $display("FAIL zero_bypass_ar: got %h want 0", ar); end
        @(negedge clock);
        idle(); iss_en = 1'b1; iss_addr = 3'd0;
        #1;
        n_tests++; if (ar !== 16'h0) begin n_fail++; $display("FAIL zero_array_ar: got %h want 0", ar); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_issue_stall: got %b want 0", stall); end
        @(negedge clock);
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_reissue_stall: got %b want 0", stall); end
        n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL zero_pending: got %0d want 0", pending); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_raw();
        test_waw();
        test_back_to_back();
`ifdef REGFILE_ZERO_REG_EN
        test_zero_reg();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
